ras_spec: RTL

Speculative return address stack: the successor to the basic front-end RAS. Calls push the return PC and returns pop the predicted target. When the stack is full, a push overwrites the oldest entry instead of being dropped. A same-cycle push and pop replaces the top entry. A small checkpoint queue lets the branch unit roll the stack back after a misprediction. The block sits in the fetch stage beside the BTB; the decode/branch unit drives checkpoint save, retire and restore.

---
 rtl/ras_pkg.sv | 26 ++
 rtl/ras_ckpt_queue.sv | 78 +++++++
 rtl/ras_spec.sv | 105 ++++++++++
 3 files changed

// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared sizing helpers and checkpoint record for the return address stack
package ras_pkg;

    localparam int RAS_PC_WIDTH = 32;
    localparam int RAS_ASIZE    = 3;
    localparam int RAS_CSIZE    = 2;

    function automatic int depth_of(input int asize);
        return 1 << asize;
    endfunction

    function automatic int nckpt_of(input int csize);
        return 1 << csize;
    endfunction

    localparam int RAS_DEPTH = depth_of(RAS_ASIZE);
    localparam int RAS_NCKPT = nckpt_of(RAS_CSIZE);

    // Checkpoint record for the default geometry; the top re-declares it with its own widths.
    typedef struct packed {
        logic [RAS_ASIZE-1:0]    tosp;
        logic [RAS_ASIZE:0]      count;
        logic [RAS_PC_WIDTH-1:0] top;
    } ckpt_t;

endpackage

// File: rtl/ras_ckpt_queue.sv
// rtl/ras_ckpt_queue.sv - checkpoint FIFO with save, retire and restore truncation
module ras_ckpt_queue
    import ras_pkg::*;
#(
    parameter int CSIZE = 2,
    parameter int W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             save,
    input  logic             retire,
    input  logic             restore,
    input  logic [CSIZE-1:0] restore_id,
    input  logic [W-1:0]     save_data,
    output logic [CSIZE-1:0] tail_id,
    output logic             full,
    output logic             restore_hit,
    output logic [W-1:0]     restore_data
);

    localparam int NCKPT = nckpt_of(CSIZE);

    logic [W-1:0]     entries [NCKPT];
    logic [CSIZE-1:0] head, tail, head_n, tail_n;
    logic [CSIZE:0]   occ, occ_n;
    logic [CSIZE-1:0] offset;
    logic             retire_ok, save_ok;

    assign offset       = restore_id - head;
    assign full         = (occ == (CSIZE+1)'(NCKPT));
    assign tail_id      = tail;
    assign restore_hit  = restore && ({1'b0, offset} < occ);
    assign restore_data = entries[restore_id];
    assign retire_ok    = retire && (occ != '0);
    // A retire in the same cycle frees the slot the save lands in, so a full queue still accepts it.
    assign save_ok      = save && !restore_hit && (!full || retire_ok);

    always_comb begin
        head_n = head;
        tail_n = tail;
        occ_n  = occ;
        if (restore_hit) begin
            tail_n = restore_id;
            occ_n  = {1'b0, offset};
            if (retire && (offset != '0)) begin
                head_n = head + CSIZE'(1);
                occ_n  = {1'b0, offset} - (CSIZE+1)'(1);
            end
        end else begin
            if (save_ok) begin
                tail_n = tail + CSIZE'(1);
            end
            if (retire_ok) begin
                head_n = head + CSIZE'(1);
            end
            occ_n = occ + (CSIZE+1)'(save_ok) - (CSIZE+1)'(retire_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < NCKPT; i++) begin
                entries[i] <= '0;
            end
        end else begin
            head <= head_n;
            tail <= tail_n;
            occ  <= occ_n;
            if (save_ok) begin
                entries[tail] <= save_data;
            end
        end
    end

endmodule

// File: rtl/ras_spec.sv
// rtl/ras_spec.sv - speculative return address stack with overwrite-on-full and checkpoint rollback
module ras_spec
    import ras_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int ASIZE    = 3,
    parameter int CSIZE    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic [PC_WIDTH-1:0] push_addr_i,
    input  logic                pop_i,
    output logic [PC_WIDTH-1:0] ret_addr_o,
    output logic                ret_valid_o,
    input  logic                ckpt_save_i,
    output logic [CSIZE-1:0]    ckpt_id_o,
    output logic                ckpt_full_o,
    input  logic                ckpt_retire_i,
    input  logic                restore_i,
    input  logic [CSIZE-1:0]    restore_id_i
);

    localparam int DEPTH = depth_of(ASIZE);

    typedef struct packed {
        logic [ASIZE-1:0]    tosp;
        logic [ASIZE:0]      count;
        logic [PC_WIDTH-1:0] top;
    } snap_t;

    localparam int SW = $bits(snap_t);

    logic [PC_WIDTH-1:0] stack [DEPTH];
    logic [ASIZE-1:0]    tosp, tosp_n, wr_idx;
    logic [ASIZE:0]      count, count_n;
    logic                wr_en;
    logic [PC_WIDTH-1:0] wr_data;
    snap_t               save_snap, rest_snap;
    logic                rest_hit;

    assign ret_addr_o  = stack[tosp];
    assign ret_valid_o = (count != '0);
    assign save_snap   = '{tosp: tosp, count: count, top: stack[tosp]};

    ras_ckpt_queue #(
        .CSIZE (CSIZE),
        .W     (SW)
    ) u_ckpt (
        .clk          (clk),
        .rst          (rst),
        .save         (ckpt_save_i),
        .retire       (ckpt_retire_i),
        .restore      (restore_i),
        .restore_id   (restore_id_i),
        .save_data    (save_snap),
        .tail_id      (ckpt_id_o),
        .full         (ckpt_full_o),
        .restore_hit  (rest_hit),
        .restore_data (rest_snap)
    );

    always_comb begin
        tosp_n  = tosp;
        count_n = count;
        wr_en   = 1'b0;
        wr_idx  = tosp;
        wr_data = push_addr_i;
        if (rest_hit) begin
            // Rewriting the saved top repairs a slot clobbered by wrong-path push-after-pop.
            tosp_n  = rest_snap.tosp;
            count_n = rest_snap.count;
            wr_en   = 1'b1;
            wr_idx  = rest_snap.tosp;
            wr_data = rest_snap.top;
        end else if (push_i && pop_i && (count != '0)) begin
            wr_en = 1'b1;
        end else if (push_i) begin
            tosp_n  = tosp + ASIZE'(1);
            wr_en   = 1'b1;
            wr_idx  = tosp + ASIZE'(1);
            count_n = (count == (ASIZE+1)'(DEPTH)) ? count : count + (ASIZE+1)'(1);
        end else if (pop_i && (count != '0)) begin
            tosp_n  = tosp - ASIZE'(1);
            count_n = count - (ASIZE+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tosp  <= ASIZE'(DEPTH - 1);
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            tosp  <= tosp_n;
            count <= count_n;
            if (wr_en) begin
                stack[wr_idx] <= wr_data;
            end
        end
    end

endmodule
